// File: rtl/mesh_injector.sv
// Streaming packet injector for the sorting mesh: fills N load slots,
// pulses load+start, times the sort window. Optional: MESH_INJ_SNAKE_EN.
module mesh_injector #(
  parameter int N           = 256,
  parameter int SQRT_N      = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int SORT_CYCLES = 112
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]      in_pkt,
  input  logic                                  in_last,
  output logic [N*(ADDR_WIDTH+DATA_WIDTH)-1:0]  pe_load_data,
  output logic                                  pe_load_en,
  output logic                                  mesh_start,
  output logic                                  busy,
  output logic                                  sort_done,
  output logic                                  short_frame
);

  localparam int WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW    = $clog2(N + 1);
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int TW    = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_SORT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [CW-1:0]     r_cnt;
  logic [TW-1:0]     r_tmr;
  logic              r_short;
  logic [WIDTH-1:0]  r_slot [N];

  logic              w_acc;
  logic              w_first;
  logic              w_nth;
  logic [CW-1:0]     w_row;
  logic [CW-1:0]     w_col;
  logic [CW-1:0]     w_idx_full;
  logic [IW-1:0]     w_idx;

  assign in_ready = rst && (r_state != S_LOAD) && (r_state != S_SORT);
  assign w_acc    = in_valid && in_ready;
  assign w_first  = w_acc && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_nth    = (r_cnt == CW'(N - 1));

  always_comb begin
    w_row = r_cnt / CW'(SQRT_N);
    w_col = r_cnt % CW'(SQRT_N);
`ifdef MESH_INJ_SNAKE_EN
    // odd rows run right-to-left (shearsort snake order)
    if (w_row[0]) w_col = CW'(SQRT_N - 1) - w_col;
`endif
    w_idx_full = w_row * CW'(SQRT_N) + w_col;
  end

  assign w_idx = w_idx_full[IW-1:0];

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_acc) w_nxt = (in_last || N == 1) ? S_LOAD : S_FILL;
      end
      S_FILL: begin
        if (w_acc && (in_last || w_nth)) w_nxt = S_LOAD;
      end
      S_LOAD: w_nxt = S_SORT;
      S_SORT: begin
        if (r_tmr == TW'(SORT_CYCLES - 1)) w_nxt = S_DONE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tmr   <= '0;
      r_short <= 1'b0;
      for (int s = 0; s < N; s++)
        r_slot[s] <= {ADDR_WIDTH'(s), {DATA_WIDTH{1'b1}}};
    end else begin
      r_state <= w_nxt;
      if (r_state == S_LOAD)      r_tmr <= '0;
      else if (r_state == S_SORT) r_tmr <= r_tmr + TW'(1);
      if (w_first) begin
        // a new frame wipes the previous one back to pad values
        for (int s = 0; s < N; s++)
          r_slot[s] <= {ADDR_WIDTH'(s), {DATA_WIDTH{1'b1}}};
        r_slot[0] <= in_pkt;
        r_cnt     <= CW'(1);
        r_short   <= in_last && (N > 1);
      end else if (w_acc) begin
        if (w_idx_full < CW'(N)) r_slot[w_idx] <= in_pkt;
        r_cnt <= r_cnt + CW'(1);
        if (in_last && !w_nth) r_short <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign pe_load_data[g*WIDTH +: WIDTH] = r_slot[g];
  end

  assign pe_load_en  = (r_state == S_LOAD);
  assign mesh_start  = (r_state == S_LOAD);
  assign busy        = (r_state == S_LOAD) || (r_state == S_SORT);
  assign sort_done   = (r_state == S_DONE);
  assign short_frame = r_short;

endmodule

// File: tb/tb_mesh_injector.sv
// Directed scoreboard bench for mesh_injector.
// Slot expectations queued at drive time, checked at the load pulse.
module tb_mesh_injector;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_pkt = '0;
  logic          in_last = 1'b0;
  logic [4095:0] pe_load_data;
  logic          pe_load_en;
  logic          mesh_start;
  logic          busy;
  logic          sort_done;
  logic          short_frame;

  int nc = 0;
  int nm = 0;
  int npulse = 0;

  typedef struct {
    int          idx;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  mesh_injector dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pkt       (in_pkt),
    .in_last      (in_last),
    .pe_load_data (pe_load_data),
    .pe_load_en   (pe_load_en),
    .mesh_start   (mesh_start),
    .busy         (busy),
    .sort_done    (sort_done),
    .short_frame  (short_frame)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pe_load_en) npulse++;

  function automatic int slot_of(int k);
    int r;
    int c;
    r = k / 16;
    c = k % 16;
`ifdef MESH_INJ_SNAKE_EN
    if (r % 2 == 1) c = 15 - c;
`endif
    return r * 16 + c;
  endfunction

  function automatic logic [15:0] slot(int s);
    return pe_load_data[s*16 +: 16];
  endfunction

  function automatic logic [15:0] pad(int s);
    logic [31:0] v;
    v = s;
    return {v[7:0], 8'hFF};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nc++;
    assert (obs === exp) else begin
      nm++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic push(int k, logic [15:0] v);
    exp_t e;
    e.idx = slot_of(k);
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_sb(string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(tag, slot(e.idx), e.val);
    end
  endtask

  // called at a negedge; returns at the negedge after the accept
  task automatic send(input logic [15:0] p, input logic last,
                      output int stalls);
    in_valid = 1'b1;
    in_pkt   = p;
    in_last  = last;
    stalls   = 0;
    while (!in_ready && stalls < 500) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 500) chk("accept_timeout", stalls, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!sort_done && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int st;
    int n;
    int p0;
    logic bad;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_en", pe_load_en, 0);
    chk("rst_start", mesh_start, 0);
    chk("rst_done", sort_done, 0);
    chk("rst_short", short_frame, 0);
    for (int s = 0; s < 256; s++) chk("rst_pad", slot(s), pad(s));
    rst = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // full frame, in_last together with the Nth accept
    p0 = npulse;
    for (int k = 0; k < 256; k++) begin
      push(k, {8'(255 - k), 8'(k)});
      send({8'(255 - k), 8'(k)}, k == 255, st);
    end
    chk("t1_load_en", pe_load_en, 1);
    chk("t1_start", mesh_start, 1);
    chk("t1_busy", busy, 1);
    chk("t1_load_ready", in_ready, 0);
    chk("t1_short", short_frame, 0);
    check_sb("t1_slot");
    wait_done(n);
    chk("t1_done_lat", n, 113);
    chk("t1_pulses", npulse - p0, 1);
    chk("t1_done_busy", busy, 0);

    // short frame
    for (int k = 0; k < 10; k++) begin
      push(k, {8'(k), 8'h00});
      send({8'(k), 8'h00}, k == 9, st);
    end
    chk("t2_load_en", pe_load_en, 1);
    chk("t2_short", short_frame, 1);
    check_sb("t2_slot");
    chk("t2_pad10", slot(slot_of(10)), 16'h0AFF);
    chk("t2_pad255", slot(255), 16'hFFFF);

    // held beat stalls through LOAD+SORT, lands in slot 0
    push(0, 16'hA55A);
    send(16'hA55A, 1'b0, st);
    chk("t3_stalls", st, 113);
    chk("t3_done_fall", sort_done, 0);
    chk("t3_short_clr", short_frame, 0);
    chk("t3_fill_busy", busy, 0);

    // no in_last: the Nth accept closes the frame
    for (int k = 1; k < 256; k++) begin
      push(k, {8'(k), ~8'(k)});
      send({8'(k), ~8'(k)}, 1'b0, st);
    end
    chk("t4_load_en", pe_load_en, 1);
    chk("t4_short", short_frame, 0);
    check_sb("t4_slot");
    push(0, 16'h7711);
    send(16'h7711, 1'b0, st);
    chk("t4_b257_stalls", st, 113);
    push(1, 16'h2233);
    send(16'h2233, 1'b1, st);
    chk("t4_b258_stalls", st, 0);
    chk("t4b_load_en", pe_load_en, 1);
    chk("t4b_short", short_frame, 1);
    check_sb("t4b_slot");
    chk("t4b_pad2", slot(slot_of(2)), pad(slot_of(2)));

    // reset in the middle of the sort window
    repeat (51) @(negedge clk);
    chk("t5_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_load_en", pe_load_en, 0);
    chk("t5_start", mesh_start, 0);
    chk("t5_done", sort_done, 0);
    chk("t5_short", short_frame, 0);
    chk("t5_in_ready", in_ready, 0);
    for (int s = 0; s < 256; s++) chk("t5_pad", slot(s), pad(s));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rel_ready", in_ready, 1);
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      bad = bad | sort_done | busy | pe_load_en;
    end
    chk("t5_quiet", bad, 0);

`ifdef MESH_INJ_SNAKE_EN
    for (int k = 0; k < 256; k++) begin
      push(k, {8'(k), 8'(k)});
      send({8'(k), 8'(k)}, k == 255, st);
    end
    chk("t6_load_en", pe_load_en, 1);
    chk("t6_s31", slot(31), 16'h1010);
    chk("t6_s16", slot(16), 16'h1F1F);
    chk("t6_s32", slot(32), 16'h2020);
    check_sb("t6_slot");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nm);
    $finish;
  end

endmodule
